// File: rtl/alu_seq_pkg.sv
// Shared constants for the sequential ALU: decoded ALU codes, instruction
// classes and FSM state encoding.
package alu_seq_pkg;

  // Decoded ALU operation codes
  localparam logic [3:0] AluNone = 4'b0000;
  localparam logic [3:0] AluAnd  = 4'b0001;
  localparam logic [3:0] AluAdd  = 4'b0010;
  localparam logic [3:0] AluSub  = 4'b0011;
  localparam logic [3:0] AluCmp  = 4'b0100;
  localparam logic [3:0] AluBeq  = 4'b0101;
  localparam logic [3:0] AluSll  = 4'b1100;
  localparam logic [3:0] AluSlr  = 4'b1101;
  localparam logic [3:0] AluSllv = 4'b1110;
  localparam logic [3:0] AluSlrv = 4'b1111;

  // Instruction classes; 2'b01 is reserved and always illegal
  localparam logic [1:0] ItypeR = 2'b00;
  localparam logic [1:0] ItypeI = 2'b10;
  localparam logic [1:0] ItypeS = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StExec  = 2'b01,
    StShift = 2'b10
  } state_e;

  // All shift codes share the 2'b11 prefix
  function automatic logic is_shift(input logic [3:0] code);
    return code[3:2] == 2'b11;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of (instr_type, opcode) into a 4-bit ALU code.
module alu_ctrl_decode
  import alu_seq_pkg::*;
#(
  parameter int unsigned OPC_W = 6
) (
  input  logic [1:0]       instr_type_i,
  input  logic [OPC_W-1:0] opcode_i,
  output logic [3:0]       code_o,
  output logic             illegal_o
);

  // Table decode; anything not listed is illegal with code 0000
  always_comb begin
    code_o    = AluNone;
    illegal_o = 1'b1;
    unique case (instr_type_i)
      ItypeR: begin
        if (opcode_i < OPC_W'(4)) begin
          illegal_o = 1'b0;
          unique case (opcode_i[1:0])
            2'd0:    code_o = AluAnd;
            2'd1:    code_o = AluAdd;
            2'd2:    code_o = AluSub;
            default: code_o = AluCmp;
          endcase
        end
      end
      ItypeI: begin
        if (opcode_i == OPC_W'(0)) begin
          illegal_o = 1'b0;
          code_o    = AluAnd;
        end else if (opcode_i < OPC_W'(4)) begin
          illegal_o = 1'b0;
          code_o    = AluAdd;
        end else if (opcode_i == OPC_W'(4)) begin
          illegal_o = 1'b0;
          code_o    = AluBeq;
        end
      end
      ItypeS: begin
        if (opcode_i < OPC_W'(4)) begin
          illegal_o = 1'b0;
          code_o    = {2'b11, opcode_i[1:0]};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Multi-cycle ALU: single-cycle ops through EXEC, shifts one bit per cycle
// through SHIFT, with synchronous flush and a one-cycle done pulse.
module alu_seq_unit
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPC_W = 6,
  parameter int unsigned SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       instr_type,
  input  logic [OPC_W-1:0] opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SH_W-1:0]  shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic [3:0]       alu_ctrl
);

  state_e state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d, exec_res, shift_nxt;
  logic [SH_W-1:0]  cnt_q, cnt_d, req_cnt;
  logic [3:0]       ctrl_q, ctrl_d, dec_code;
  logic             pend_q, pend_d, dec_illegal;
  logic             done_q, done_d, zero_q, zero_d, illegal_q, illegal_d;

  alu_ctrl_decode #(
    .OPC_W (OPC_W)
  ) u_decode (
    .instr_type_i (instr_type),
    .opcode_i     (opcode),
    .code_o       (dec_code),
    .illegal_o    (dec_illegal)
  );

  // Variable shifts take their count from b, immediate shifts from shamt
  assign req_cnt = (dec_code == AluSllv || dec_code == AluSlrv) ? b[SH_W-1:0] : shamt;

  // Code bit 0 selects right (logical) versus left shift
  assign shift_nxt = ctrl_q[0] ? (acc_q >> 1) : (acc_q << 1);

  // Single-cycle result; a zero-count shift passes a through unchanged
  always_comb begin
    exec_res = '0;
    unique case (ctrl_q)
      AluAnd:                          exec_res = a_q & b_q;
      AluAdd:                          exec_res = a_q + b_q;
      AluSub, AluBeq:                  exec_res = a_q - b_q;
      AluCmp:                          exec_res = {{(WIDTH-1){1'b0}},
                                                   $signed(a_q) < $signed(b_q)};
      AluSll, AluSlr, AluSllv, AluSlrv: exec_res = a_q;
      default:                         exec_res = '0;
    endcase
  end

  // Next-state logic; flush wins over both acceptance and completion
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    pend_d    = pend_q;
    done_d    = 1'b0;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_d    = a;
            b_d    = b;
            acc_d  = a;
            ctrl_d = dec_code;
            pend_d = dec_illegal;
            cnt_d  = is_shift(dec_code) ? req_cnt : '0;
            state_d = (is_shift(dec_code) && req_cnt != '0) ? StShift : StExec;
          end
        end
        StExec: begin
          state_d   = StIdle;
          done_d    = 1'b1;
          illegal_d = pend_q;
          result_d  = pend_q ? '0 : exec_res;
          zero_d    = pend_q || (exec_res == '0);
        end
        StShift: begin
          acc_d = shift_nxt;
          cnt_d = cnt_q - SH_W'(1);
          if (cnt_q == SH_W'(1)) begin
            state_d   = StIdle;
            done_d    = 1'b1;
            illegal_d = 1'b0;
            result_d  = shift_nxt;
            zero_d    = (shift_nxt == '0);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ctrl_q    <= AluNone;
      pend_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      pend_q    <= pend_d;
      done_q    <= done_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign result   = result_q;
  assign zero     = zero_q;
  assign illegal  = illegal_q;
  assign alu_ctrl = ctrl_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit (WIDTH=32): directed cases, random ops
// against a table-driven reference model, flush/reset abort and back-to-back.
module tb_alu_seq_unit;

  logic        clk, rst_n, start, flush;
  logic [1:0]  instr_type;
  logic [5:0]  opcode;
  logic [31:0] op_a, op_b;
  logic [4:0]  shamt;
  logic        busy, done, zero, illegal;
  logic [31:0] result;
  logic [3:0]  alu_ctrl;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_result = '0;
  logic        exp_zero   = 1'b1;
  logic        exp_ill    = 1'b0;

  alu_seq_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .flush      (flush),
    .instr_type (instr_type),
    .opcode     (opcode),
    .a          (op_a),
    .b          (op_b),
    .shamt      (shamt),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .zero       (zero),
    .illegal    (illegal),
    .alu_ctrl   (alu_ctrl)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference: decode table, arithmetic by mnemonic, latency = shift count (min 1)
  function automatic void model(input logic [1:0] it, input logic [5:0] op,
                                input logic [31:0] xa, input logic [31:0] xb,
                                input logic [4:0] sh, output logic [3:0] code,
                                output logic ill, output logic [31:0] res, output int lat);
    int k;
    code = 4'h0;
    ill  = 1'b1;
    res  = '0;
    lat  = 1;
    if (it == 2'b00 && op < 4) begin
      ill = 1'b0; code = 4'(op) + 4'd1;
    end else if (it == 2'b10 && op == 0) begin
      ill = 1'b0; code = 4'd1;
    end else if (it == 2'b10 && op <= 3) begin
      ill = 1'b0; code = 4'd2;
    end else if (it == 2'b10 && op == 4) begin
      ill = 1'b0; code = 4'd5;
    end else if (it == 2'b11 && op < 4) begin
      ill = 1'b0; code = 4'd12 + 4'(op);
    end
    if (!ill) begin
      case (code)
        4'd1:       res = xa & xb;
        4'd2:       res = xa + xb;
        4'd3, 4'd5: res = xa - xb;
        4'd4:       res = ($signed(xa) < $signed(xb)) ? 32'd1 : 32'd0;
        default: begin
          k   = (code >= 4'd14) ? int'(xb[4:0]) : int'(sh);
          res = code[0] ? (xa >> k) : (xa << k);
          lat = (k == 0) ? 1 : k;
        end
      endcase
    end
  endfunction

  task automatic drive(input logic [1:0] it, input logic [5:0] op, input logic [31:0] xa,
                       input logic [31:0] xb, input logic [4:0] sh);
    instr_type = it; opcode = op; op_a = xa; op_b = xb; shamt = sh; start = 1'b1;
  endtask

  // Issue one op, wait (bounded) for done, compare latency and outputs.
  // poke >= 0 asserts a stray start that many cycles into the operation.
  task automatic run_op(input logic [1:0] it, input logic [5:0] op, input logic [31:0] xa,
                        input logic [31:0] xb, input logic [4:0] sh, input int poke,
                        input bit no_sync);
    logic [3:0]  code;
    logic        ill;
    logic [31:0] res;
    int          lat, c;
    bit          seen;
    model(it, op, xa, xb, sh, code, ill, res, lat);
    if (!no_sync) @(negedge clk);
    drive(it, op, xa, xb, sh);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check_eq("accept_busy", busy, 1);
    check_eq("alu_ctrl", alu_ctrl, code);
    check_eq("no_early_done", done, 0);
    c = 0;
    seen = 1'b0;
    while (!seen && c < 80) begin
      if (c == poke) drive(2'b00, 6'd1, 32'd0, 32'd0, 5'd0);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      c++;
      if (done) seen = 1'b1;
      else check_eq("busy_hold", busy, 1);
    end
    check_eq("done_seen", seen, 1);
    if (seen) begin
      exp_result = res;
      exp_zero   = (res == 32'd0);
      exp_ill    = ill;
      check_eq("latency", c, lat);
      check_eq("result", result, exp_result);
      check_eq("zero", zero, exp_zero);
      check_eq("illegal", illegal, exp_ill);
      check_eq("idle_in_done", busy, 0);
      @(posedge clk);
      @(negedge clk);
      check_eq("done_pulse_1cyc", done, 0);
      check_eq("no_queued_op", busy, 0);
      check_eq("result_held", result, exp_result);
    end
  endtask

  task automatic watch_no_done(input string tag, input int cycles);
    int hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) hits++;
    end
    check_eq(tag, hits, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_result"}, result, 0);
    check_eq({tag, "_zero"}, zero, 1);
    check_eq({tag, "_illegal"}, illegal, 0);
    check_eq({tag, "_alu_ctrl"}, alu_ctrl, 0);
  endtask

  initial begin
    logic [1:0]  it;
    logic [5:0]  op;
    logic [31:0] xa, xb;
    int          c;
    bit          seen;

    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    instr_type = 2'b00; opcode = '0; op_a = '0; op_b = '0; shamt = '0;
    #12;
    check_reset_outputs("reset");

    // First start accepted on the first edge after release; ADD wraps to zero
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'b00, 6'd1, 32'hFFFF_FFFF, 32'd1, 5'd0, -1, 1'b1);
    // SLLV 1<<5 with a stray start two cycles in
    run_op(2'b11, 6'd2, 32'd1, 32'd5, 5'd0, 2, 1'b0);
    run_op(2'b00, 6'd3, 32'h8000_0000, 32'd1, 5'd0, -1, 1'b0);  // CMP signed
    run_op(2'b10, 6'd4, 32'd7, 32'd7, 5'd0, -1, 1'b0);          // BEQ equal
    run_op(2'b01, 6'd0, 32'd3, 32'd4, 5'd0, -1, 1'b0);          // illegal class
    run_op(2'b00, 6'd0, 32'hF0F0, 32'hFF00, 5'd0, -1, 1'b0);    // legal clears illegal
    run_op(2'b11, 6'd0, 32'h1234, 32'd0, 5'd0, -1, 1'b0);       // SLL by 0
    run_op(2'b11, 6'd3, 32'hFFFF_FFFF, 32'd31, 5'd0, -1, 1'b0); // SLRV by 31

    for (int i = 0; i < 40; i++) begin
      it = 2'($urandom_range(0, 3));
      op = 6'($urandom_range(0, 7));
      xa = $urandom;
      xb = ($urandom_range(0, 3) == 0) ? xa : $urandom;
      run_op(it, op, xa, xb, 5'($urandom), -1, 1'b0);
    end

    // Flush mid-shift: no done, idle next edge, previous result held
    run_op(2'b00, 6'd1, 32'd3, 32'd4, 5'd0, -1, 1'b0);
    @(negedge clk);
    drive(2'b11, 6'd1, 32'h8000_0000, 32'd0, 5'd31);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("flush_pre_busy", busy, 1);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check_eq("flush_idle", busy, 0);
    check_eq("flush_no_done", done, 0);
    check_eq("flush_result_held", result, exp_result);
    check_eq("flush_zero_held", zero, exp_zero);
    check_eq("flush_illegal_held", illegal, exp_ill);
    watch_no_done("flush_silent", 40);

    // Same op aborted by reset: outputs return to reset values at once
    @(negedge clk);
    drive(2'b11, 6'd1, 32'h8000_0000, 32'd0, 5'd31);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midop_reset");
    @(negedge clk);
    rst_n = 1'b1;
    exp_result = '0; exp_zero = 1'b1; exp_ill = 1'b0;
    watch_no_done("reset_silent", 40);

    // Back-to-back: second start in the done cycle of the first
    @(negedge clk);
    drive(2'b00, 6'd1, 32'd10, 32'd20, 5'd0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("b2b_first_done", done, 1);
    check_eq("b2b_first_result", result, 30);
    drive(2'b11, 6'd0, 32'd3, 32'd0, 5'd3);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check_eq("b2b_second_busy", busy, 1);
    check_eq("b2b_second_ctrl", alu_ctrl, 4'b1100);
    check_eq("b2b_gap_no_done", done, 0);
    c = 0;
    seen = 1'b0;
    while (!seen && c < 80) begin
      @(posedge clk);
      @(negedge clk);
      c++;
      if (done) seen = 1'b1;
    end
    check_eq("b2b_second_done", seen, 1);
    check_eq("b2b_second_latency", c, 3);
    check_eq("b2b_second_result", result, 24);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal 8..64).
REQ-002 SHALL have parameter OPC_W, default 6, opcode field width.
REQ-003 SHALL have parameter SH_W, default $clog2(WIDTH), shift-amount width.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-007 SHALL have port flush  input  1  synchronous abort of any in-flight operation.
REQ-008 SHALL have port instr_type  input  2  00 R, 10 I, 11 S; 01 illegal.
REQ-009 SHALL have port opcode  input  OPC_W  operation select.
REQ-010 SHALL have ports a, b  input  WIDTH  operands.
REQ-011 SHALL have port shamt  input  SH_W  immediate shift amount.
REQ-012 SHALL have port busy  output  1  high in EXEC or SHIFT.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port result  output  WIDTH  registered result, held until next done.
REQ-015 SHALL have port zero  output  1  registered, result == 0.
REQ-016 SHALL have port illegal  output  1  registered with done; undecodable request.
REQ-017 SHALL have port alu_ctrl  output  4  registered decoded code of accepted request.

Function
REQ-018 Decode SHALL be: R 0/1/2/3 -> AND 0001/ADD 0010/SUB 0011/CMP 0100; I 0 -> AND, 1..3 -> ADD, 4 -> BEQ 0101; S 0/1/2/3 -> SLL 1100/SLR 1101/SLLV 1110/SLRV 1111; all else illegal, alu_ctrl 0000.
REQ-019 FSM states SHALL be IDLE, EXEC, SHIFT; start in IDLE at edge N captures a, b, shift count, alu_ctrl.
REQ-020 Non-shift or illegal request SHALL go IDLE -> EXEC -> IDLE; result, zero, done valid after edge N+1.
REQ-021 Shift count SHALL be shamt for SLL/SLR, b[SH_W-1:0] for SLLV/SLRV.
REQ-022 Shift with count k>=1 SHALL go to SHIFT, shift accumulator one bit per edge, done after edge N+k; k=0 SHALL use EXEC path, result = a, done after N+1.
REQ-023 SLR/SLRV SHALL be logical (zero fill); SLL/SLLV zero fill.
REQ-024 ADD/SUB SHALL wrap modulo 2^WIDTH, no carry/overflow output.
REQ-025 CMP SHALL return 1 if signed a < b else 0, zero-extended.
REQ-026 BEQ SHALL return a - b; zero high iff a == b.
REQ-027 Illegal request SHALL pulse done with illegal=1, result=0, zero=1.
REQ-028 start while busy SHALL be ignored, no queuing.
REQ-029 FSM SHALL be in IDLE during the done cycle; start in that cycle SHALL be accepted.
REQ-030 flush SHALL force IDLE on next edge, suppress done, leave result/zero unchanged; flush has priority over start and completion.
REQ-031 illegal SHALL be cleared on next legal done.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, busy=0, done=0, result=0, zero=1, illegal=0, alu_ctrl=0000, internal count=0.
REQ-033 Reset mid-operation SHALL discard the operation with no done after release.
REQ-034 First start SHALL be accepted on first rising edge with rst_n high.

Structure
REQ-035 Package alu_seq_pkg SHALL hold 4-bit ALU code constants, instr_type constants and FSM state encoding.
REQ-036 Combinational decode SHALL live in sub-module alu_ctrl_decode (instr_type, opcode -> code, illegal).
REQ-037 Datapath, counter and FSM SHALL be in alu_seq_unit; single clock domain, no latches.

Verification
REQ-038 R ADD a=0xFFFFFFFF b=1, WIDTH=32 -> done after N+1, result=0, zero=1, illegal=0.
REQ-039 S SLLV a=1 b=5 -> busy 5 cycles, done after N+5, result=0x20; start at N+2 ignored.
REQ-040 R CMP a=0x80000000 b=1 -> result=1; I BEQ a=b=7 -> result=0, zero=1.
REQ-041 instr_type=01 -> done after N+1, illegal=1, result=0, alu_ctrl=0000.
REQ-042 S SLR a=0x80000000 shamt=31, flush at N+3 -> no done, IDLE at N+4, prior result held; repeat with rst_n low at N+3 -> all outputs reset values.
REQ-043 Back-to-back: start asserted in done cycle -> second op accepted, done pulses separated by its latency.
